// File: rtl/branch_unit_sched_pkg.sv
// Shared types for the branch-unit scheduler: request operands, resolution and exception
// records, scheduler state encoding and the block-trigger helper.
package branch_unit_sched_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned NrBranchPorts = 2;

  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = '0;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JUMP,
    CF_JUMPR,
    CF_RETURN
  } cf_t;

  typedef enum logic [1:0] {
    OP_BRANCH,
    OP_JALR
  } fu_op_t;

  typedef struct packed {
    cf_t             cf;
    logic [XLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    fu_op_t          operation;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] imm;
    logic [2:0]      trans_id;
  } fu_data_t;

  typedef struct packed {
    fu_data_t           fu_data;
    logic [XLEN-1:0]    pc;
    logic               is_compressed;
    logic               comp_res;
    branchpredict_sbe_t predict;
  } bu_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
    cf_t             cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef enum logic {
    ST_RUN,
    ST_WAIT_FLUSH
  } sched_state_e;

  // A resolution that redirects the frontend or traps must stop further issue.
  function automatic logic blocks_issue(bp_resolve_t res, exception_t exc);
    return res.is_mispredict | exc.valid;
  endfunction

endpackage

// File: rtl/branch_unit_sched_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above ptr_i, wrapping to the
// lowest requesting index overall when nothing at or above the pointer is asserted.
module branch_rr_arbiter #(
  parameter  int unsigned NrPorts = 2,
  localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NrPorts-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  logic [NrPorts-1:0] upper_mask;
  logic [NrPorts-1:0] masked_req;
  logic [NrPorts-1:0] sel_req;

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_mask
    assign upper_mask[gi] = (IdxW'(gi) >= ptr_i);
    assign gnt_o[gi]      = valid_o && (idx_o == IdxW'(gi));
  end

  assign masked_req = req_i & upper_mask;
  assign sel_req    = (|masked_req) ? masked_req : req_i;
  assign valid_o    = |req_i;

  // Scan downwards so the last match written is the lowest set index.
  always_comb begin
    idx_o = '0;
    for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
      if (sel_req[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/branch_unit_sched.sv
// Shares one branch unit between NrPorts issue lanes: round-robin grant, issue register in
// front of the unit, result register behind it, and an issue block after redirects/traps.
module branch_unit_sched
  import branch_unit_sched_pkg::*;
#(
  parameter  int unsigned NrPorts  = NrBranchPorts,
  parameter  int unsigned CntWidth = 32,
  localparam int unsigned IdxW     = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NrPorts-1:0]      req_valid_i,
  output logic [NrPorts-1:0]      req_ready_o,
  input  bu_req_t [NrPorts-1:0]   req_i,
  output logic                    bu_valid_o,
  output bu_req_t                 bu_req_o,
  input  bp_resolve_t             bu_resolved_i,
  input  exception_t              bu_exception_i,
  output bp_resolve_t             resolved_branch_o,
  output exception_t              branch_exception_o,
  output logic [IdxW-1:0]         grant_port_o,
  output logic                    blocked_o,
  output logic [CntWidth-1:0]     mispredict_cnt_o
);

  sched_state_e        state_q, state_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic                issue_valid_q, issue_valid_d;
  bu_req_t             issue_req_q, issue_req_d;
  bp_resolve_t         res_q, res_d;
  exception_t          exc_q, exc_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic                trigger;
  logic                grant_en;
  logic                capture;
  logic [NrPorts-1:0]  arb_req;
  logic [NrPorts-1:0]  arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_valid;

  // The op that causes the block is the last one let through, so gate grants in the same cycle.
  assign trigger  = issue_valid_q & blocks_issue(bu_resolved_i, bu_exception_i);
  assign grant_en = (state_q == ST_RUN) & ~flush_i & ~trigger;
  assign arb_req  = req_valid_i & {NrPorts{grant_en}};
  assign capture  = issue_valid_q & ~flush_i;

  branch_rr_arbiter #(
    .NrPorts (NrPorts)
  ) i_arbiter (
    .req_i   (arb_req),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    grant_d        = grant_q;
    issue_valid_d  = 1'b0;
    issue_req_d    = '0;
    res_d          = res_q;
    res_d.valid    = 1'b0;
    exc_d          = exc_q;
    exc_d.valid    = 1'b0;
    cnt_d          = cnt_q;

    if (arb_valid) begin
      issue_valid_d = 1'b1;
      issue_req_d   = req_i[arb_idx];
      grant_d       = arb_idx;
      rr_d          = (arb_idx == IdxW'(NrPorts - 1)) ? '0 : arb_idx + 1'b1;
    end

    if (capture) begin
      res_d = bu_resolved_i;
      exc_d = bu_exception_i;
      if (bu_resolved_i.is_mispredict && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    if (flush_i) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && trigger) begin
      state_d = ST_WAIT_FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      rr_q          <= '0;
      grant_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_req_q   <= '0;
      res_q         <= '0;
      exc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      issue_valid_q <= issue_valid_d;
      issue_req_q   <= issue_req_d;
      res_q         <= res_d;
      exc_q         <= exc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready_o        = arb_gnt;
  assign bu_valid_o         = issue_valid_q;
  assign bu_req_o           = issue_req_q;
  assign resolved_branch_o  = res_q;
  assign branch_exception_o = exc_q;
  assign grant_port_o       = grant_q;
  assign blocked_o          = (state_q == ST_WAIT_FLUSH);
  assign mispredict_cnt_o   = cnt_q;

endmodule
